// File: rtl/debug_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : debug_pattern_checker
// Purpose  : Drains the colour-bar debug FIFO, rebuilds frame/row structure
//            and checks every pixel against the bar colour of its column.
// Revision : 1.0  initial release
// ============================================================================
module debug_pattern_checker #(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int NUM_COLOR_BARS = 10,
  parameter bit STOP_ON_ERROR  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        queue_empty,
  output logic        queue_rd_en,
  input  logic [16:0] queue_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        error,
  output logic [20:0] pixel_count,
  output logic [10:0] row_count,
  output logic [15:0] mismatch_count,
  output logic [10:0] err_col,
  output logic [10:0] err_row
);

  localparam int          c_BAR_W     = FRAME_WIDTH / NUM_COLOR_BARS;
  localparam logic [10:0] c_FRAME_W   = 11'(FRAME_WIDTH);
  localparam logic [10:0] c_FRAME_H   = 11'(FRAME_HEIGHT);
  localparam logic [10:0] c_NUM_BARS  = 11'(NUM_COLOR_BARS);
  localparam logic [10:0] c_BAR_W_M1  = 11'(c_BAR_W - 1);

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_ROW      = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q;
  logic        enable_q;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        error_q, error_d;
  logic [20:0] pix_q, pix_d;
  logic [10:0] row_q, row_d;
  logic [10:0] col_q, col_d;
  logic [10:0] bar_idx_q, bar_idx_d;
  logic [10:0] bar_pos_q, bar_pos_d;
  logic [10:0] err_col_q, err_col_d;
  logic [10:0] err_row_q, err_row_d;
  logic [15:0] mism_q, mism_d;

  logic        w_is_ctrl;
  logic        w_sof;
  logic        w_eor;
  logic [15:0] w_expect;
  logic        w_err_evt;
  logic        w_close;

  function automatic logic [15:0] bar_colour(input logic [10:0] idx);
    case (idx)
      11'd0:   bar_colour = 16'hFFFF;
      11'd1:   bar_colour = 16'hFFE0;
      11'd2:   bar_colour = 16'h07FF;
      11'd3:   bar_colour = 16'h07E0;
      11'd4:   bar_colour = 16'hF81F;
      11'd5:   bar_colour = 16'hF800;
      11'd6:   bar_colour = 16'h001F;
      11'd7:   bar_colour = 16'h0000;
      11'd8:   bar_colour = 16'h8410;
      11'd9:   bar_colour = 16'hFC00;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  assign w_is_ctrl   = queue_data[16];
  assign w_sof       = w_is_ctrl && (queue_data[15:0] == 16'h0000);
  assign w_eor       = w_is_ctrl && (queue_data[15:0] == 16'h0001);
  // Bar index saturates at NUM_COLOR_BARS, which covers the leftover columns.
  assign w_expect    = (bar_idx_q < c_NUM_BARS) ? bar_colour(bar_idx_q) : 16'h0000;
  assign queue_rd_en = enable && !queue_empty && (state_q != S_HALT);

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    error_d      = error_q;
    pix_d        = pix_q;
    row_d        = row_q;
    col_d        = col_q;
    bar_idx_d    = bar_idx_q;
    bar_pos_d    = bar_pos_q;
    err_col_d    = err_col_q;
    err_row_d    = err_row_q;
    mism_d       = mism_q;
    w_err_evt    = 1'b0;
    w_close      = 1'b0;

    if (state_q == S_HALT) begin
      if (enable && !enable_q) state_d = S_WAIT_SOF;
    end else if (valid_q) begin
      if (w_sof) begin
        if (state_q == S_ROW) begin
          frame_done_d = 1'b1;
          frame_ok_d   = 1'b0;
        end
        state_d   = S_ROW;
        error_d   = 1'b0;
        pix_d     = '0;
        row_d     = '0;
        col_d     = '0;
        bar_idx_d = '0;
        bar_pos_d = '0;
        err_col_d = '0;
        err_row_d = '0;
        mism_d    = '0;
      end else if (w_is_ctrl && !w_eor) begin
        w_err_evt = 1'b1;
      end else if (state_q == S_WAIT_SOF) begin
        w_err_evt = 1'b1;
      end else if (w_eor) begin
        if (col_q != c_FRAME_W) w_err_evt = 1'b1;
        row_d     = row_q + 11'd1;
        col_d     = '0;
        bar_idx_d = '0;
        bar_pos_d = '0;
        if ((row_q + 11'd1) == c_FRAME_H) begin
          w_close      = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_WAIT_SOF;
        end
      end else begin
        pix_d = pix_q + 21'd1;
        if (col_q != 11'h7FF) col_d = col_q + 11'd1;
        if (col_q >= c_FRAME_W) begin
          w_err_evt = 1'b1;
        end else if (queue_data[15:0] != w_expect) begin
          w_err_evt = 1'b1;
          if (mism_q != 16'hFFFF) mism_d = mism_q + 16'd1;
        end
        if (bar_pos_q == c_BAR_W_M1) begin
          bar_pos_d = '0;
          if (bar_idx_q != c_NUM_BARS) bar_idx_d = bar_idx_q + 11'd1;
        end else begin
          bar_pos_d = bar_pos_q + 11'd1;
        end
      end
    end

    // Location is captured from the counters before this word advanced them.
    if (w_err_evt) begin
      error_d = 1'b1;
      if (!error_q) begin
        err_col_d = col_q;
        err_row_d = row_q;
        if (STOP_ON_ERROR) state_d = S_HALT;
      end
    end

    if (w_close) frame_ok_d = !error_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT_SOF;
      valid_q      <= 1'b0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      error_q      <= 1'b0;
      pix_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      bar_idx_q    <= '0;
      bar_pos_q    <= '0;
      err_col_q    <= '0;
      err_row_q    <= '0;
      mism_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= queue_rd_en;
      enable_q     <= enable;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      error_q      <= error_d;
      pix_q        <= pix_d;
      row_q        <= row_d;
      col_q        <= col_d;
      bar_idx_q    <= bar_idx_d;
      bar_pos_q    <= bar_pos_d;
      err_col_q    <= err_col_d;
      err_row_q    <= err_row_d;
      mism_q       <= mism_d;
    end
  end

  assign frame_done     = frame_done_q;
  assign frame_ok       = frame_ok_q;
  assign error          = error_q;
  assign pixel_count    = pix_q;
  assign row_count      = row_q;
  assign mismatch_count = mism_q;
  assign err_col        = err_col_q;
  assign err_row        = err_row_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_pattern_checker
// Purpose  : Self-checking bench: FIFO model, stream builder and a word-level
//            reference model of the expected frame results.
// Revision : 1.0  initial release
// ============================================================================
module tb_debug_pattern_checker;

  localparam int FW  = 640;
  localparam int FH  = 10;
  localparam int NB  = 10;
  localparam int HFW = 64;
  localparam int HFH = 4;
  localparam int HNB = 10;
  localparam logic [16:0] SOF = 17'h1_0000;
  localparam logic [16:0] EOR = 17'h1_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        enable, enable_h;
  logic        queue_empty = 1'b1, queue_empty_h = 1'b1;
  logic        queue_rd_en, queue_rd_en_h;
  logic [16:0] queue_data = '0, queue_data_h = '0;
  logic        frame_done, frame_ok, error;
  logic        frame_done_h, frame_ok_h, error_h;
  logic [20:0] pixel_count, pixel_count_h;
  logic [10:0] row_count, row_count_h, err_col, err_col_h, err_row, err_row_h;
  logic [15:0] mismatch_count, mismatch_count_h;

  debug_pattern_checker #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .NUM_COLOR_BARS(NB),
                          .STOP_ON_ERROR(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .queue_empty(queue_empty),
    .queue_rd_en(queue_rd_en), .queue_data(queue_data), .frame_done(frame_done),
    .frame_ok(frame_ok), .error(error), .pixel_count(pixel_count), .row_count(row_count),
    .mismatch_count(mismatch_count), .err_col(err_col), .err_row(err_row));

  debug_pattern_checker #(.FRAME_WIDTH(HFW), .FRAME_HEIGHT(HFH), .NUM_COLOR_BARS(HNB),
                          .STOP_ON_ERROR(1'b1)) dut_h (
    .clk(clk), .reset_n(reset_n), .enable(enable_h), .queue_empty(queue_empty_h),
    .queue_rd_en(queue_rd_en_h), .queue_data(queue_data_h), .frame_done(frame_done_h),
    .frame_ok(frame_ok_h), .error(error_h), .pixel_count(pixel_count_h),
    .row_count(row_count_h), .mismatch_count(mismatch_count_h), .err_col(err_col_h),
    .err_row(err_row_h));

  int checks = 0;
  int errors = 0;

  logic [16:0] fifo[$], fifo_h[$], stream[$];
  bit          gap_mode = 1'b0;
  int          cyc = 0, last_pop_cyc = 0, done_cyc = 0, rd_empty = 0;
  bit          got_done[$], got_done_h[$], exp_done[$];
  logic [16:0] pop_w, pop_wh;

  // FIFO models: registered Q, empty flag refreshed every clock.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (queue_rd_en && queue_empty) rd_empty <= rd_empty + 1;
    if (queue_rd_en && fifo.size() > 0) begin
      pop_w = fifo.pop_front();
      queue_data   <= pop_w;
      last_pop_cyc <= cyc;
    end
    queue_empty <= (fifo.size() == 0) || (gap_mode && ($urandom_range(0, 1) == 1));
  end
  always @(posedge clk) begin
    if (queue_rd_en_h && fifo_h.size() > 0) begin
      pop_wh = fifo_h.pop_front();
      queue_data_h <= pop_wh;
    end
    queue_empty_h <= (fifo_h.size() == 0);
  end

  always @(negedge clk) begin
    if (frame_done) begin
      got_done.push_back(frame_ok);
      done_cyc = cyc;
    end
    if (frame_done_h) got_done_h.push_back(frame_ok_h);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_colour(input int col, input int fw, input int nb);
    int bw;
    bw = fw / nb;
    if (col >= nb * bw) return 16'h0000;
    case (col / bw)
      0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;
      3: return 16'h07E0;  4: return 16'hF81F;  5: return 16'hF800;
      6: return 16'h001F;  7: return 16'h0000;  8: return 16'h8410;
      9: return 16'hFC00;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model state, advanced one stream word at a time.
  bit m_in, m_err;
  int m_pix, m_row, m_mism, m_ec, m_er, m_col;

  task automatic model_reset();
    m_in = 0; m_err = 0; m_pix = 0; m_row = 0; m_mism = 0; m_ec = 0; m_er = 0; m_col = 0;
    exp_done.delete();
    got_done.delete();
  endtask

  task automatic m_flag();
    if (!m_err) begin m_ec = m_col; m_er = m_row; end
    m_err = 1;
  endtask

  task automatic push_word(input logic [16:0] w);
    fifo.push_back(w);
    if (w[16]) begin
      if (w[15:0] == 16'h0000) begin
        if (m_in) exp_done.push_back(1'b0);
        m_in = 1; m_err = 0; m_pix = 0; m_row = 0; m_mism = 0; m_ec = 0; m_er = 0; m_col = 0;
      end else if (w[15:0] == 16'h0001 && m_in) begin
        if (m_col != FW) m_flag();
        m_row++;
        m_col = 0;
        if (m_row == FH) begin
          exp_done.push_back(!m_err);
          m_in = 0;
        end
      end else begin
        m_flag();
      end
    end else if (!m_in) begin
      m_flag();
    end else begin
      if (m_col >= FW) m_flag();
      else if (w[15:0] != exp_colour(m_col, FW, NB)) begin
        if (m_mism < 65535) m_mism++;
        m_flag();
      end
      m_pix++;
      m_col++;
    end
  endtask

  task automatic build_frame(input int fw, input int nb, input int nrows,
                             input int odd_row, input int odd_len);
    int len;
    stream.delete();
    stream.push_back(SOF);
    for (int r = 0; r < nrows; r++) begin
      len = (r == odd_row) ? odd_len : fw;
      for (int c = 0; c < len; c++) stream.push_back({1'b0, exp_colour(c, fw, nb)});
      stream.push_back(EOR);
    end
  endtask

  task automatic set_pixel(input int fw, input int r, input int c, input logic [15:0] v);
    stream[1 + r * (fw + 1) + c] = {1'b0, v};
  endtask

  task automatic push_stream();
    foreach (stream[i]) push_word(stream[i]);
  endtask

  task automatic drain(input string tag, input int budget, input bit toggle);
    int n = 0;
    while ((fifo.size() != 0 || queue_rd_en) && n < budget) begin
      @(negedge clk);
      if (toggle) enable = ($urandom_range(0, 3) != 0);
      n++;
    end
    enable = 1'b1;
    chk({tag, ".drain_in_budget"}, (n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".error"}, error, m_err);
    chk({tag, ".pixel_count"}, pixel_count, m_pix);
    chk({tag, ".row_count"}, row_count, m_row);
    chk({tag, ".mismatch_count"}, mismatch_count, m_mism);
    chk({tag, ".err_col"}, err_col, m_ec);
    chk({tag, ".err_row"}, err_row, m_er);
    chk({tag, ".n_frame_done"}, got_done.size(), exp_done.size());
    for (int i = 0; i < exp_done.size(); i++)
      if (i < got_done.size()) chk({tag, ".frame_ok"}, got_done[i], exp_done[i]);
    got_done.delete();
    exp_done.delete();
  endtask

  initial begin
    int n, sz, r, c;
    reset_n = 1'b0; enable = 1'b0; enable_h = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.frame_done", frame_done, 0);
    chk("reset.frame_ok", frame_ok, 0);
    chk("reset.h.error", error_h, 0);
    chk("reset.h.pixel_count", pixel_count_h, 0);
    check_state("reset");
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Clean frame, back-to-back words.
    build_frame(FW, NB, FH, -1, 0);
    push_stream();
    drain("clean", 20000, 1'b0);
    chk("clean.latency", done_cyc, last_pop_cyc + 2);
    check_state("clean");

    // Stray words while waiting for SOF.
    push_word({1'b0, 16'hFFFF});
    push_word(17'h1_0005);
    push_word(EOR);
    drain("stray", 100, 1'b0);
    check_state("stray");

    // Single bad pixel at row 5 column 130.
    build_frame(FW, NB, FH, -1, 0);
    set_pixel(FW, 5, 130, 16'h1234);
    push_stream();
    drain("badpix", 20000, 1'b0);
    check_state("badpix");

    // Short row 3.
    build_frame(FW, NB, FH, 3, FW - 1);
    push_stream();
    drain("short", 20000, 1'b0);
    check_state("short");

    // SOF after 7 rows, then a clean frame.
    build_frame(FW, NB, 7, -1, 0);
    push_stream();
    build_frame(FW, NB, FH, -1, 0);
    push_stream();
    drain("restart", 30000, 1'b0);
    check_state("restart");

    // Clean frame through random empty gaps and enable toggling.
    gap_mode = 1'b1;
    build_frame(FW, NB, FH, -1, 0);
    push_stream();
    drain("gaps", 40000, 1'b1);
    gap_mode = 1'b0;
    chk("gaps.no_read_when_empty", rd_empty, 0);
    check_state("gaps");

    // Random corruptions plus an overlong last row.
    build_frame(FW, NB, FH, FH - 1, FW + 1);
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(0, FH - 2);
      c = $urandom_range(0, FW - 1);
      set_pixel(FW, r, c, 16'($urandom));
    end
    push_stream();
    drain("random", 20000, 1'b0);
    check_state("random");

    // Halting variant: error at pixel 10, then recover with a clean frame.
    enable_h = 1'b1;
    stream.delete();
    build_frame(HFW, HNB, HFH, -1, 0);
    set_pixel(HFW, 0, 10, 16'h1234);
    foreach (stream[i]) fifo_h.push_back(stream[i]);
    n = 0;
    while (!error_h && n < 500) begin @(negedge clk); n++; end
    chk("halt.error_seen", error_h, 1);
    chk("halt.rd_en_low", queue_rd_en_h, 0);
    sz = fifo_h.size();
    repeat (5) @(negedge clk);
    chk("halt.no_more_reads", fifo_h.size(), sz);
    chk("halt.pixel_count", pixel_count_h, 11);
    chk("halt.mismatch_count", mismatch_count_h, 1);
    chk("halt.err_col", err_col_h, 10);
    chk("halt.err_row", err_row_h, 0);
    enable_h = 1'b0;
    fifo_h.delete();
    repeat (2) @(negedge clk);
    enable_h = 1'b1;
    repeat (2) @(negedge clk);
    build_frame(HFW, HNB, HFH, -1, 0);
    foreach (stream[i]) fifo_h.push_back(stream[i]);
    n = 0;
    while ((fifo_h.size() != 0 || queue_rd_en_h) && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("halt.n_frame_done", got_done_h.size(), 1);
    if (got_done_h.size() > 0) chk("halt.frame_ok", got_done_h[0], 1);
    chk("halt.clean_error", error_h, 0);
    chk("halt.clean_pixel_count", pixel_count_h, HFW * HFH);
    chk("halt.clean_row_count", row_count_h, HFH);
    chk("halt.clean_mismatch", mismatch_count_h, 0);

    // Reset in the middle of a frame.
    build_frame(FW, NB, 3, -1, 0);
    push_stream();
    n = 0;
    while (pixel_count < 700 && n < 5000) begin @(negedge clk); n++; end
    chk("midreset.progress", (pixel_count >= 700), 1);
    enable = 1'b0;
    reset_n = 1'b0;
    fifo.delete();
    model_reset();
    @(negedge clk);
    chk("midreset.frame_ok", frame_ok, 0);
    check_state("midreset");
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
